menu_select_ctrl: RTL and testbench

Parametrised level-select front end for the start screen. It decodes PS/2 key events into a menu cursor and a committed level code. It generates the scaled ROM address for the menu image and overlays a highlight box on the cursor item. It sits between the keyboard decoder and the VGA controller and drives `level` to the top-level game FSM.

---
 rtl/menu_select_ctrl_if.sv | 28 ++
 rtl/menu_select_ctrl.sv | 144 ++++++++++++++
 tb/tb_menu_select_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/menu_select_ctrl_if.sv
// Keyboard, VGA and menu-ROM signals of the level-select front end.
// slave = the menu controller, master = its surroundings.
interface menu_select_ctrl_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              ready;
    logic              keydown;
    logic [8:0]        last_change;
    logic              valid;
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic [11:0]       rom_data;
    logic [ADDR_W-1:0] pixel_addr;
    logic [11:0]       pixel;
    logic [2:0]        level;
    logic              level_valid;
    logic [2:0]        cursor;

    modport slave (
        input  ready, keydown, last_change, valid, h_cnt, v_cnt, rom_data,
        output pixel_addr, pixel, level, level_valid, cursor
    );

    modport master (
        output ready, keydown, last_change, valid, h_cnt, v_cnt, rom_data,
        input  pixel_addr, pixel, level, level_valid, cursor
    );
endinterface

// File: rtl/menu_select_ctrl.sv
// Start-screen level selector: key events move a cursor and commit a level code;
// the pixel path upscales the menu image and draws a border around the cursor item.
module menu_select_ctrl #(
    parameter int unsigned NUM_LEVELS = 3,
    parameter int unsigned IMG_W      = 160,
    parameter int unsigned IMG_H      = 120,
    parameter int unsigned SCALE_SH   = 2,
    parameter int unsigned ITEM_X0    = 200,
    parameter int unsigned ITEM_Y0    = 160,
    parameter int unsigned ITEM_W     = 240,
    parameter int unsigned ITEM_H     = 64,
    parameter logic [11:0] HILITE     = 12'hFF0,
    parameter int unsigned ADDR_W     = 15
) (
    input logic               clk,
    input logic               rst,
    menu_select_ctrl_if.slave bus
);
    localparam logic [2:0] NL        = 3'(NUM_LEVELS);
    localparam logic [8:0] KEY_HELP  = 9'h04A;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;
    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;

    typedef enum logic {SELECT, LOCKED} state_t;

    state_t     state;
    logic       prev;
    logic       press;
    logic [2:0] digit;
    logic [2:0] level_q;
    logic       level_valid_q;
    logic [2:0] cursor_q;

    assign press = bus.keydown & bus.ready & ~prev;

    always_comb begin
        digit = 3'd0;
        case (bus.last_change)
            9'h016:  digit = 3'd1;
            9'h01E:  digit = 3'd2;
            9'h026:  digit = 3'd3;
            9'h025:  digit = 3'd4;
            9'h02E:  digit = 3'd5;
            9'h036:  digit = 3'd6;
            default: digit = 3'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SELECT;
            prev          <= 1'b0;
            level_q       <= 3'd0;
            level_valid_q <= 1'b0;
            cursor_q      <= 3'd1;
        end else begin
            prev          <= bus.keydown & bus.ready;
            level_valid_q <= 1'b0;
            if (press) begin
                case (state)
                    SELECT: begin
                        if (bus.last_change == KEY_UP) begin
                            cursor_q <= (cursor_q == 3'd1) ? NL : cursor_q - 3'd1;
                        end else if (bus.last_change == KEY_DOWN) begin
                            cursor_q <= (cursor_q == NL) ? 3'd1 : cursor_q + 3'd1;
                        end else if (digit != 3'd0 && digit <= NL) begin
                            cursor_q      <= digit;
                            level_q       <= digit;
                            level_valid_q <= 1'b1;
                            state         <= LOCKED;
                        end else if (bus.last_change == KEY_ENTER) begin
                            level_q       <= cursor_q;
                            level_valid_q <= 1'b1;
                            state         <= LOCKED;
                        end else if (bus.last_change == KEY_HELP) begin
                            level_q       <= 3'd7;
                            level_valid_q <= 1'b1;
                            state         <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (bus.last_change == KEY_ESC) begin
                            level_q <= 3'd0;
                            state   <= SELECT;
                        end
                    end
                    default: state <= SELECT;
                endcase
            end
        end
    end

    assign bus.level       = level_q;
    assign bus.level_valid = level_valid_q;
    assign bus.cursor      = cursor_q;

    logic [9:0]  x;
    logic [9:0]  y;
    logic        in_img;
    logic [31:0] hx;
    logic [31:0] vy;
    logic [31:0] top;
    logic        in_box;
    logic        near_edge;
    logic        hilite;

    assign x      = bus.h_cnt >> SCALE_SH;
    assign y      = bus.v_cnt >> SCALE_SH;
    assign in_img = (32'(x) < IMG_W) && (32'(y) < IMG_H);
    assign bus.pixel_addr = in_img ? ADDR_W'(x) + ADDR_W'(IMG_W) * ADDR_W'(y) : '0;

    always_comb begin
        hx        = 32'(bus.h_cnt);
        vy        = 32'(bus.v_cnt);
        top       = ITEM_Y0 + 32'(cursor_q - 3'd1) * ITEM_H;
        in_box    = (hx >= ITEM_X0) && (hx < ITEM_X0 + ITEM_W) &&
                    (vy >= top) && (vy < top + ITEM_H);
        // Border is the 2-pixel ring just inside the box.
        near_edge = (hx < ITEM_X0 + 2) || (hx >= ITEM_X0 + ITEM_W - 2) ||
                    (vy < top + 2) || (vy >= top + ITEM_H - 2);
        hilite    = (state == SELECT) && in_box && near_edge;
    end

    logic valid_q;
    logic oob_q;
    logic hilite_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            oob_q    <= 1'b0;
            hilite_q <= 1'b0;
        end else begin
            valid_q  <= bus.valid;
            oob_q    <= ~in_img;
            hilite_q <= hilite;
        end
    end

    assign bus.pixel = (!valid_q || oob_q) ? '0 :
                       hilite_q            ? HILITE : bus.rom_data;
endmodule

// File: tb/tb_menu_select_ctrl.sv
// Randomised and directed bench for menu_select_ctrl with a queue-based scoreboard.
// A second instance with SCALE_SH=1 exercises the out-of-image address path.
module tb_menu_select_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    menu_select_ctrl_if #(.ADDR_W(15)) bus0 ();
    menu_select_ctrl_if #(.ADDR_W(15)) bus1 ();

    menu_select_ctrl #(.NUM_LEVELS(3), .SCALE_SH(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    menu_select_ctrl #(.NUM_LEVELS(3), .SCALE_SH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [11:0] rom_fn(input int a);
        return 12'((a * 13 + 7) & 'hFFF);
    endfunction

    always @(posedge clk) begin
        bus0.rom_data <= rom_fn(int'(bus0.pixel_addr));
        bus1.rom_data <= rom_fn(int'(bus1.pixel_addr));
    end

    typedef struct {
        int addr0;
        int addr1;
        int level;
        int lv;
        int cursor;
        int pix0;
        int pix1;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state
    int m_cursor = 1;
    int m_level  = 0;
    bit m_locked = 0;
    bit m_prev   = 0;
    int h_cur    = 0;
    int v_cur    = 0;

    function automatic int model_addr(input int h, input int v, input int sh);
        int x = h >> sh;
        int y = v >> sh;
        if (x < 160 && y < 120) return x + 160 * y;
        return 0;
    endfunction

    function automatic bit model_oob(input int h, input int v, input int sh);
        return !((h >> sh) < 160 && (v >> sh) < 120);
    endfunction

    function automatic int digit_of(input int code);
        int codes[6] = '{'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36};
        for (int i = 0; i < 6; i++) if (codes[i] == code) return i + 1;
        return 0;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rdy, input bit kd, input int code,
                        input bit vld, input int h, input int v);
        exp_t e;
        int   top, dmin;
        bit   hl, press;
        int   d;
        @(negedge clk);
        rst = r;
        bus0.ready = rdy; bus0.keydown = kd; bus0.last_change = 9'(code);
        bus0.valid = vld; bus0.h_cnt = 10'(h); bus0.v_cnt = 10'(v);
        bus1.ready = rdy; bus1.keydown = kd; bus1.last_change = 9'(code);
        bus1.valid = vld; bus1.h_cnt = 10'(h); bus1.v_cnt = 10'(v);
        h_cur = h; v_cur = v;

        e.addr0 = model_addr(h, v, 2);
        e.addr1 = model_addr(h, v, 1);
        top  = 160 + (m_cursor - 1) * 64;
        dmin = h - 200;
        if (439 - h < dmin) dmin = 439 - h;
        if (v - top < dmin) dmin = v - top;
        if (top + 63 - v < dmin) dmin = top + 63 - v;
        hl = !m_locked && dmin >= 0 && dmin < 2;
        e.pix0 = (r || !vld || model_oob(h, v, 2)) ? 0 :
                 hl ? 'hFF0 : int'(rom_fn(e.addr0));
        e.pix1 = (r || !vld || model_oob(h, v, 1)) ? 0 :
                 hl ? 'hFF0 : int'(rom_fn(e.addr1));

        e.lv = 0;
        if (r) begin
            m_cursor = 1; m_level = 0; m_locked = 0; m_prev = 0;
        end else begin
            press  = kd && rdy && !m_prev;
            m_prev = kd && rdy;
            if (press) begin
                d = digit_of(code);
                if (m_locked) begin
                    if (code == 'h76) begin m_level = 0; m_locked = 0; end
                end else if (code == 'h175) begin
                    m_cursor = ((m_cursor - 2 + 3) % 3) + 1;
                end else if (code == 'h172) begin
                    m_cursor = (m_cursor % 3) + 1;
                end else if (d >= 1 && d <= 3) begin
                    m_cursor = d; m_level = d; e.lv = 1; m_locked = 1;
                end else if (code == 'h5A) begin
                    m_level = m_cursor; e.lv = 1; m_locked = 1;
                end else if (code == 'h4A) begin
                    m_level = 7; e.lv = 1; m_locked = 1;
                end
            end
        end
        e.level  = m_level;
        e.cursor = m_cursor;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 1, h_cur, v_cur);
    endtask

    task automatic press_key(input int code);
        step(0, 1, 1, code, 1, h_cur, v_cur);
        idle(1);
    endtask

    // Monitor: outputs are sampled 1 ns after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("pixel_addr", int'(bus0.pixel_addr), e.addr0);
                check("pixel_addr_sh1", int'(bus1.pixel_addr), e.addr1);
                check("level", int'(bus0.level), e.level);
                check("level_valid", int'(bus0.level_valid), e.lv);
                check("cursor", int'(bus0.cursor), e.cursor);
                check("pixel", int'(bus0.pixel), e.pix0);
                check("pixel_sh1", int'(bus1.pixel), e.pix1);
            end
        end
    end

    initial begin
        int codes[12] = '{'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h4A, 'h5A, 'h76, 'h175, 'h172, 'h1C};
        int wait_cnt;
        bus0.ready = 0; bus0.keydown = 0; bus0.last_change = 0; bus0.valid = 0;
        bus0.h_cnt = 0; bus0.v_cnt = 0;
        bus1.ready = 0; bus1.keydown = 0; bus1.last_change = 0; bus1.valid = 0;
        bus1.h_cnt = 0; bus1.v_cnt = 0;

        repeat (2) step(1, 0, 0, 0, 1, 0, 0);
        press_key('h1E);
        press_key('h76);
        step(1, 0, 0, 0, 1, 0, 0);
        repeat (3) press_key('h172);
        press_key('h5A);
        step(1, 0, 0, 0, 1, 0, 0);
        repeat (50) step(0, 1, 1, 'h16, 1, 0, 0);
        idle(1);
        press_key('h76);
        press_key('h26);
        press_key('h16);
        press_key('h76);
        press_key('h4A);
        press_key('h76);
        press_key('h5A);
        press_key('h76);
        press_key('h175);
        press_key('h175);
        press_key('h36);

        step(1, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 5, 9);
        step(0, 0, 0, 0, 1, 639, 479);
        step(0, 0, 0, 0, 1, 400, 100);
        step(0, 0, 0, 0, 1, 200, 160);
        step(0, 0, 0, 0, 1, 300, 200);
        step(0, 0, 0, 0, 0, 300, 200);
        step(0, 0, 0, 0, 1, 439, 223);
        step(1, 0, 0, 0, 1, 201, 161);
        step(0, 0, 0, 0, 1, 201, 161);

        for (int i = 0; i < 1500; i++) begin
            bit r   = ($urandom_range(0, 199) == 0);
            bit rdy = $urandom_range(0, 1);
            bit kd  = ($urandom_range(0, 2) != 0);
            bit vld = ($urandom_range(0, 7) != 0);
            int code = codes[$urandom_range(0, 11)];
            int h, v;
            if ($urandom_range(0, 1) == 1) begin
                h = $urandom_range(195, 445);
                v = $urandom_range(155, 357);
            end else begin
                h = $urandom_range(0, 639);
                v = $urandom_range(0, 479);
            end
            step(r, rdy, kd, code, vld, h, v);
        end

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
